// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo pair layout used by the sample pacer.
package audio_pkg;

    localparam int unsigned AUDIO_DATA_BIT       = 16;
    localparam int unsigned AUDIO_CLK_FREQ_HZ    = 100_000_000;
    localparam int unsigned AUDIO_SAMPLE_RATE_HZ = 48_000;

    // One FIFO entry: left and right travel together.
    typedef struct packed {
        logic [AUDIO_DATA_BIT-1:0] left;
        logic [AUDIO_DATA_BIT-1:0] right;
    } stereo_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; pointers carry one extra wrap bit.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces buffered stereo pairs out at SAMPLE_RATE_HZ using a phase accumulator.
// Optional underrun statistics port/counter enabled by AUDIO_PACER_STATS_EN.
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int unsigned DATA_BIT       = AUDIO_DATA_BIT,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned CLK_FREQ_HZ    = AUDIO_CLK_FREQ_HZ,
    parameter int unsigned SAMPLE_RATE_HZ = AUDIO_SAMPLE_RATE_HZ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BIT-1:0]           s_left,
    input  logic [DATA_BIT-1:0]           s_right,
    output logic [DATA_BIT-1:0]           audio_l,
    output logic [DATA_BIT-1:0]           audio_r,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
`ifdef AUDIO_PACER_STATS_EN
   ,input  logic                          stats_clear,
    output logic [15:0]                   underrun_count
`endif
);
    localparam int unsigned ACC_W = $clog2(CLK_FREQ_HZ) + 1;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             wrap;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    stereo_pair_t     push_pair;
    stereo_pair_t     head_pair;

    assign acc_sum = acc + ACC_W'(SAMPLE_RATE_HZ);
    assign wrap    = (acc_sum >= ACC_W'(CLK_FREQ_HZ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else       acc <= wrap ? (acc_sum - ACC_W'(CLK_FREQ_HZ)) : acc_sum;
    end

    // Readiness depends on occupancy only, so a same-cycle pop never frees a full FIFO.
    assign s_ready        = !reset && !fifo_full;
    assign push           = s_valid && s_ready;
    assign pop            = wrap && !fifo_empty;
    assign push_pair.left  = s_left;
    assign push_pair.right = s_right;

    sync_fifo #(
        .WIDTH ($bits(stereo_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_pair),
        .pop   (pop),
        .rdata (head_pair),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            audio_l     <= '0;
            audio_r     <= '0;
        end else begin
            sample_tick <= wrap;
            underrun    <= wrap && fifo_empty;
            if (pop) begin
                audio_l <= head_pair.left;
                audio_r <= head_pair.right;
            end
        end
    end

`ifdef AUDIO_PACER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       underrun_count <= '0;
        else if (stats_clear)                            underrun_count <= '0;
        else if (wrap && fifo_empty && underrun_count != '1) underrun_count <= underrun_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Self-checking bench for audio_sample_pacer: per-cycle reference model plus directed scenarios.
module tb_audio_sample_pacer;
    import audio_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam longint unsigned CLK_HZ = 100_000_000;
    localparam longint unsigned SR_HZ  = 48_000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic [DW-1:0] audio_l;
    logic [DW-1:0] audio_r;
    logic          sample_tick;
    logic [3:0]    fifo_level;
    logic          underrun;
`ifdef AUDIO_PACER_STATS_EN
    logic          stats_clear = 1'b0;
    logic [15:0]   underrun_count;
`endif

    audio_sample_pacer #(
        .DATA_BIT       (DW),
        .FIFO_DEPTH     (DEPTH),
        .CLK_FREQ_HZ    (100_000_000),
        .SAMPLE_RATE_HZ (48_000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_left         (s_left),
        .s_right        (s_right),
        .audio_l        (audio_l),
        .audio_r        (audio_r),
        .sample_tick    (sample_tick),
        .fifo_level     (fifo_level),
        .underrun       (underrun)
`ifdef AUDIO_PACER_STATS_EN
       ,.stats_clear    (stats_clear),
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
            if (failures >= 40) finish_tb();
        end
    endtask

    // Tick n (n = clock edges since reset release) happens whenever floor(n*SR/CLK) advances.
    function automatic bit is_tick(input longint unsigned n);
        return ((n * SR_HZ) / CLK_HZ) != (((n - 1) * SR_HZ) / CLK_HZ);
    endfunction

    function automatic longint unsigned next_wrap(input longint unsigned c);
        longint unsigned n = c + 1;
        while (!is_tick(n)) n++;
        return n;
    endfunction

    // Reference model: queue of pairs, popped on each tick, pushed when not full.
    logic [31:0]     q[$];
    logic [DW-1:0]   m_l = '0;
    logic [DW-1:0]   m_r = '0;
    bit              m_tick = 1'b0;
    bit              m_uf = 1'b0;
    longint unsigned cyc = 0;
    logic [31:0]     m_head;
    bit              m_t;
    bit              m_push;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_l = '0; m_r = '0; m_tick = 1'b0; m_uf = 1'b0; cyc = 0;
        end else begin
            cyc++;
            m_t    = is_tick(cyc);
            m_push = s_valid && (q.size() < DEPTH);
            m_tick = m_t;
            m_uf   = m_t && (q.size() == 0);
            if (m_t && q.size() > 0) begin
                m_head = q.pop_front();
                m_l = m_head[31:16];
                m_r = m_head[15:0];
            end
            if (m_push) q.push_back({s_left, s_right});
        end
    end

    logic [38:0]     got_vec;
    logic [38:0]     exp_vec;
    longint unsigned last_tick = 0;
    longint unsigned spacing;

    always @(negedge clk) begin
        got_vec = {sample_tick, underrun, s_ready, fifo_level, audio_l, audio_r};
        exp_vec = {m_tick, m_uf, !reset && (q.size() < DEPTH), 4'(q.size()), m_l, m_r};
        check("model_cycle", 64'(got_vec), 64'(exp_vec));
        if (reset) last_tick = 0;
        else if (sample_tick) begin
            if (last_tick != 0) begin
                spacing = cyc - last_tick;
                checks++;
                if (spacing != 2083 && spacing != 2084) begin
                    failures++;
                    $display("FAIL tick_spacing actual=%0d required=2083..2084", spacing);
                end
            end
            last_tick = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            step();
            ok = sample_tick;
        end
        check({name, "_tick_wait"}, 64'(ok), 64'd1);
    endtask

    task automatic push_on_cycle(input longint unsigned n, input logic [DW-1:0] l, input logic [DW-1:0] r);
        for (int i = 0; i < 3000 && cyc + 1 < n; i++) step();
        check("push_align", cyc + 1, n);
        s_valid = 1'b1; s_left = l; s_right = r;
        step();
        s_valid = 1'b0;
    endtask

    typedef struct {
        bit          push;
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        bit          exp_uf;
        logic [3:0]  exp_level;
    } vec_t;

    vec_t vecs[5];
    int   rates[4];
    longint unsigned first_wrap;
    longint unsigned w;

    initial begin
        vecs[0] = '{1'b1, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b0, 4'd1};
        vecs[1] = '{1'b1, 16'h3333, 16'h4444, 16'h0000, 16'h0000, 1'b0, 4'd2};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 1'b0, 4'd1};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h3333, 16'h4444, 1'b0, 4'd0};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h3333, 16'h4444, 1'b1, 4'd0};
        rates   = '{3, 0, 1, 5};
        first_wrap = (CLK_HZ + SR_HZ - 1) / SR_HZ;

        // Reset state and first tick
        repeat (3) step();
        check("reset_state", 64'({s_ready, fifo_level, sample_tick, underrun, audio_l, audio_r}), 64'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(s_ready), 64'd1);
        wait_tick("first");
        check("first_tick_cycle", cyc, first_wrap);
        check("first_tick_underrun", 64'(underrun), 64'd1);
        check("first_tick_audio", 64'({audio_l, audio_r}), 64'd0);

        // Table: two pushes, then three ticks
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].push) begin
                s_valid = 1'b1; s_left = vecs[i].l; s_right = vecs[i].r;
                step();
                s_valid = 1'b0;
                check("vec_push_level", 64'(fifo_level), 64'(vecs[i].exp_level));
            end else begin
                wait_tick("vec");
                check("vec_audio", 64'({audio_l, audio_r}), 64'({vecs[i].exp_l, vecs[i].exp_r}));
                check("vec_underrun", 64'(underrun), 64'(vecs[i].exp_uf));
                check("vec_level", 64'(fifo_level), 64'(vecs[i].exp_level));
            end
        end

        // Push landing on the wrap cycle with the FIFO empty
        w = next_wrap(cyc);
        push_on_cycle(w, 16'h5555, 16'h6666);
        check("wrap_push_tick", 64'({sample_tick, underrun}), 64'b11);
        check("wrap_push_level", 64'(fifo_level), 64'd1);
        // Push and pop together with one entry held: level unchanged
        w = next_wrap(cyc);
        push_on_cycle(w, 16'h7777, 16'h8888);
        check("pushpop_tick", 64'({sample_tick, underrun}), 64'b10);
        check("pushpop_audio", 64'({audio_l, audio_r}), 64'h5555_6666);
        check("pushpop_level", 64'(fifo_level), 64'd1);
        wait_tick("pushpop_next");
        check("pushpop_next_audio", 64'({audio_l, audio_r}), 64'h7777_8888);
        check("pushpop_next_level", 64'(fifo_level), 64'd0);

        // Fill to full, then hold a ninth pair through the next tick
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_left = 16'(16'hA000 + i); s_right = 16'(16'hB000 + i);
            step();
        end
        check("fill_level", 64'(fifo_level), 64'd8);
        check("fill_ready", 64'(s_ready), 64'd0);
        s_left = 16'hA008; s_right = 16'hB008;
        wait_tick("fill");
        check("full_pop_level", 64'(fifo_level), 64'd7);
        check("full_pop_audio", 64'({audio_l, audio_r}), 64'hA000_B000);
        step();
        s_valid = 1'b0;
        check("ninth_accept_level", 64'(fifo_level), 64'd8);

        // Reset mid-operation discards contents
        reset = 1'b1;
        #1;
        check("midreset_state", 64'({s_ready, fifo_level, audio_l, audio_r}), 64'd0);
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("midreset_ready", 64'({s_ready, fifo_level}), 64'b1_0000);
        wait_tick("midreset");
        check("midreset_first_tick", cyc, first_wrap);
        check("midreset_underrun", 64'({underrun, audio_l, audio_r}), 64'h1_0000_0000);

        // Randomised traffic at several push densities, checked by the model
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 4200; i++) begin
                s_valid = ($urandom_range(0, 999) < rates[s]);
                s_left  = 16'($urandom);
                s_right = 16'($urandom);
                step();
            end
        end
        s_valid = 1'b0;

`ifdef AUDIO_PACER_STATS_EN
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("stats_reset", 64'(underrun_count), 64'd0);
        for (int i = 0; i < 3; i++) wait_tick("stats");
        check("stats_count3", 64'(underrun_count), 64'd3);
        w = next_wrap(cyc);
        for (int i = 0; i < 3000 && cyc + 1 < w; i++) step();
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        check("stats_clear_tick", 64'({underrun, underrun_count}), 64'h1_0000);
`endif

        step();
        finish_tb();
    end

    initial begin
        #1_500_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
        finish_tb();
    end

endmodule

// File: doc/audio_sample_pacer.md
AUDIO_SAMPLE_PACER -- requirements
Module: audio_sample_pacer

Interface
REQ-001 SHALL have parameter DATA_BIT, default 16: bits per channel sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: stereo-pair entries buffered; power of two, minimum 2.
REQ-003 SHALL have parameter CLK_FREQ_HZ, default 100_000_000: frequency of clk.
REQ-004 SHALL have parameter SAMPLE_RATE_HZ, default 48_000: output sample rate.
REQ-005 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port s_valid  input  1  upstream pair valid.
REQ-008 SHALL have port s_ready  output  1  pacer can accept a pair.
REQ-009 SHALL have port s_left  input  DATA_BIT  left sample.
REQ-010 SHALL have port s_right  input  DATA_BIT  right sample.
REQ-011 SHALL have port audio_l  output  DATA_BIT  paced left sample, feeds the i2s transmitter.
REQ-012 SHALL have port audio_r  output  DATA_BIT  paced right sample, feeds the i2s transmitter.
REQ-013 SHALL have port sample_tick  output  1  one-cycle pulse per sample period.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently held.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse when a tick finds the FIFO empty.

Function
REQ-016 SHALL generate ticks with a phase accumulator: each cycle next = acc + SAMPLE_RATE_HZ; if next >= CLK_FREQ_HZ then acc <= next - CLK_FREQ_HZ and tick, else acc <= next.
REQ-017 SHALL size the accumulator as $clog2(CLK_FREQ_HZ)+1 bits, so that the sum cannot overflow.
REQ-018 SHALL produce exactly SAMPLE_RATE_HZ ticks per CLK_FREQ_HZ cycles; tick spacing SHALL be 2083 or 2084 cycles at the defaults.
REQ-019 SHALL register the tick; sample_tick asserts in the cycle after the accumulator wraps.
REQ-020 SHALL accept a pair when s_valid && s_ready; s_ready = (fifo_level != FIFO_DEPTH).
REQ-021 SHALL NOT accept a push while full, even when a pop occurs in the same cycle.
REQ-022 SHALL store pairs in FIFO order; s_left and s_right SHALL travel together as one entry.
REQ-023 SHALL, on a tick with the FIFO non-empty, pop the head and drive it on audio_l/audio_r in the same cycle that sample_tick is high (pop-to-output latency 1 cycle from the wrap).
REQ-024 SHALL, on a tick with the FIFO empty, hold audio_l/audio_r at their previous values and pulse underrun coincident with sample_tick.
REQ-025 SHALL hold audio_l/audio_r constant between ticks, with no glitch.
REQ-026 SHALL, on a simultaneous push and tick with the FIFO empty, treat the FIFO as empty: underrun pulses, and the pushed pair is popped on the next tick.
REQ-027 SHALL, on a simultaneous push and pop with the FIFO neither empty nor full, leave fifo_level unchanged.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH, using an extra pointer bit for the full/empty distinction.

Reset
REQ-029 SHALL, while reset is high, clear the accumulator, FIFO pointers, audio_l, audio_r, sample_tick and underrun to 0, and drive s_ready to 0.
REQ-030 SHALL assert s_ready in the first clk cycle after reset deasserts.
REQ-031 SHALL discard FIFO contents when reset asserts mid-operation.
REQ-032 SHALL produce the first tick ceil(CLK_FREQ_HZ/SAMPLE_RATE_HZ) cycles after reset release, plus 1 cycle of register delay.

Configuration
REQ-033 SHALL, when AUDIO_PACER_STATS_EN is defined, add the following ports:
- underrun_count  output  16: saturating count of underrun pulses, reset to 0.
- stats_clear  input  1: synchronous clear of the count; clear wins over a same-cycle increment.
REQ-034 SHALL, when AUDIO_PACER_STATS_EN is undefined, omit those ports and the counter logic; all other behaviour is identical.

Structure
REQ-035 SHALL take the stereo pair typedef (two DATA_BIT fields) and the default rate constants from shared package audio_pkg.
REQ-036 SHALL implement buffering in sub-module sync_fifo (single clock, parameterised width and depth, with level output); tick generation and output registers stay in the top module.

Verification
REQ-037 Reset release with no pushes: first sample_tick at cycle 2084 or 2085; underrun pulses with it; audio_l = audio_r = 0.
REQ-038 Push 0x1111/0x2222, then 0x3333/0x4444: outputs 0x1111/0x2222 on tick 1 and 0x3333/0x4444 on tick 2; then hold through tick 3 with underrun = 1.
REQ-039 Push continuously with no ticks: s_ready drops after 8 accepts; fifo_level = 8; the 9th pair is not accepted until after the next tick.
REQ-040 Force push on the cycle of the first wrap with the FIFO empty: underrun pulses; that pair appears on the following tick.
REQ-041 Run 100_000_000 cycles: exactly 48_000 sample_tick pulses; every spacing is 2083 or 2084 cycles.
REQ-042 With AUDIO_PACER_STATS_EN: 3 empty ticks -> underrun_count = 3; stats_clear asserted on a tick cycle -> count = 0.
